// File: rtl/key_expansion_engine_if.sv
// Key-load and round-key streaming bundle for the AES-128 key schedule engine.
// The master side loads keys and pulls words; the slave side is the engine.
interface key_expansion_engine_if;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         abort;
    logic [31:0]  rk_word;
    logic [5:0]   rk_index;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;
    logic         busy;

    modport master (
        output key_in, key_valid, abort, rk_ready,
        input  key_ready, rk_word, rk_index, rk_round,
        input  rk_valid, rk_last, busy
    );

    modport slave (
        input  key_in, key_valid, abort, rk_ready,
        output key_ready, rk_word, rk_index, rk_round,
        output rk_valid, rk_last, busy
    );
endinterface

// File: rtl/key_expansion_engine.sv
// Streaming AES-128 key schedule: emits w[0..43] one word per handshake.
// SubWord uses LANES S-boxes per cycle, optionally followed by a register.
module key_expansion_engine #(
    parameter int LANES     = 4,
    parameter int SBOX_PIPE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    key_expansion_engine_if.slave  bus
);
    localparam int GROUPS = 4 / LANES;
    localparam int STEPS  = GROUPS + SBOX_PIPE;

    typedef enum logic [2:0] {
        IDLE, EMIT_KEY, CALC, SUB, EMIT
    } state_t;

    state_t      state;
    logic [31:0] win [4];
    logic [7:0]  rcon;
    logic [5:0]  idx;
    logic [2:0]  step;
    logic [7:0]  tmp [4];
    logic [7:0]  sb_q [LANES];
    logic [31:0] rk_word_q;
    logic        rk_valid_q;
    logic        rk_last_q;

    logic [31:0] rot;
    logic [7:0]  sb_in [LANES];
    logic [7:0]  sb_out [LANES];
    logic [7:0]  fin [4];
    logic [31:0] sub_rc;

    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as a^254 in GF(2^8), then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    assign rot = {win[3][23:0], win[3][31:24]};

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            sb_in[l] = 8'h00;
            for (int j = 0; j < 4; j++) begin
                if (j == int'(step) * LANES + l)
                    sb_in[l] = rot[31 - 8 * j -: 8];
            end
            sb_out[l] = sbox(sb_in[l]);
        end
    end

    // Write-back lags the S-box input by SBOX_PIPE steps.
    always_comb begin
        for (int j = 0; j < 4; j++) fin[j] = tmp[j];
        if (int'(step) >= SBOX_PIPE) begin
            for (int l = 0; l < LANES; l++) begin
                for (int j = 0; j < 4; j++) begin
                    if (j == (int'(step) - SBOX_PIPE) * LANES + l)
                        fin[j] = (SBOX_PIPE != 0) ? sb_q[l] : sb_out[l];
                end
            end
        end
        sub_rc = {fin[0] ^ rcon, fin[1], fin[2], fin[3]};
    end

    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            state      <= IDLE;
            rcon       <= 8'h00;
            idx        <= 6'd0;
            step       <= 3'd0;
            rk_word_q  <= 32'h0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            for (int j = 0; j < 4; j++) begin
                win[j] <= 32'h0;
                tmp[j] <= 8'h00;
            end
            for (int l = 0; l < LANES; l++) sb_q[l] <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.key_valid) begin
                        win[0]     <= bus.key_in[127:96];
                        win[1]     <= bus.key_in[95:64];
                        win[2]     <= bus.key_in[63:32];
                        win[3]     <= bus.key_in[31:0];
                        rk_word_q  <= bus.key_in[127:96];
                        rk_valid_q <= 1'b1;
                        rk_last_q  <= 1'b0;
                        idx        <= 6'd0;
                        rcon       <= 8'h01;
                        state      <= EMIT_KEY;
                    end
                end
                EMIT_KEY: begin
                    if (bus.rk_ready) begin
                        idx <= idx + 6'd1;
                        if (idx == 6'd3) begin
                            rk_valid_q <= 1'b0;
                            step       <= 3'd0;
                            state      <= SUB;
                        end else begin
                            rk_word_q <= win[idx[1:0] + 2'd1];
                        end
                    end
                end
                CALC: begin
                    if (idx[1:0] == 2'd0) begin
                        step  <= 3'd0;
                        state <= SUB;
                    end else begin
                        rk_word_q  <= win[0] ^ win[3];
                        rk_valid_q <= 1'b1;
                        rk_last_q  <= (idx == 6'd43);
                        state      <= EMIT;
                    end
                end
                SUB: begin
                    step <= step + 3'd1;
                    for (int l = 0; l < LANES; l++) sb_q[l] <= sb_out[l];
                    if (int'(step) >= SBOX_PIPE) begin
                        for (int j = 0; j < 4; j++) tmp[j] <= fin[j];
                    end
                    if (step == 3'(STEPS - 1)) begin
                        rk_word_q  <= win[0] ^ sub_rc;
                        rk_valid_q <= 1'b1;
                        rk_last_q  <= (idx == 6'd43);
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.rk_ready) begin
                        win[0] <= win[1];
                        win[1] <= win[2];
                        win[2] <= win[3];
                        win[3] <= rk_word_q;
                        if (idx[1:0] == 2'd0) rcon <= xtime(rcon);
                        if (idx == 6'd43) begin
                            rk_valid_q <= 1'b0;
                            rk_last_q  <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            idx <= idx + 6'd1;
                            // Non-SubWord successor is ready in the same cycle.
                            if (idx[1:0] == 2'd3) begin
                                rk_valid_q <= 1'b0;
                                step       <= 3'd0;
                                state      <= SUB;
                            end else begin
                                rk_word_q <= win[1] ^ rk_word_q;
                                rk_last_q <= (idx + 6'd1 == 6'd43);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.key_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rk_word   = rk_word_q;
    assign bus.rk_index  = idx;
    assign bus.rk_round  = idx[5:2];
    assign bus.rk_valid  = rk_valid_q;
    assign bus.rk_last   = rk_last_q;
endmodule

// File: tb/tb_key_expansion_engine.sv
// Bench for key_expansion_engine: table-driven FIPS-197 key schedule model,
// random stalls, abort/reset mid-stream and per-configuration timing.
module tb_key_expansion_engine;
    localparam logic [127:0] T1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ALT_KEY = 128'hdeadbeef0123456789abcdeffedcba98;

    localparam logic [127:0] SB_ROW [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [127:0] row;
        row = SB_ROW[a[7:4]];
        return row[127 - 8 * int'(a[3:0]) -: 8];
    endfunction

    function automatic int gap_exp(input int n, input int l, input int p);
        return (n % 4 == 0) ? 1 + 4 / l + p : 1;
    endfunction

    logic [31:0] exp_w [44];
    logic [31:0] t1_w [44];
    logic [31:0] got_w [44];

    task automatic model(input logic [127:0] k);
        logic [31:0] t;
        for (int i = 0; i < 4; i++) exp_w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = exp_w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
                t[31:24] = t[31:24] ^ RCON[i / 4 - 1];
            end
            exp_w[i] = exp_w[i - 4] ^ t;
        end
    endtask

    key_expansion_engine_if bus ();

    key_expansion_engine #(
        .LANES     (4),
        .SBOX_PIPE (1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Timing sweep across every LANES/SBOX_PIPE combination.
    bit t3_kv  = 1'b0;
    bit t3_on  = 1'b0;
    bit t3_fin = 1'b0;

    for (genvar g = 0; g < 6; g++) begin : g_t3
        localparam int L = (g < 2) ? 1 : (g < 4) ? 2 : 4;
        localparam int P = g % 2;
        key_expansion_engine_if t3_if ();
        assign t3_if.key_in    = T1_KEY;
        assign t3_if.key_valid = t3_kv;
        assign t3_if.abort     = 1'b0;
        assign t3_if.rk_ready  = 1'b1;
        key_expansion_engine #(
            .LANES     (L),
            .SBOX_PIPE (P)
        ) u_t3 (
            .clk (clk),
            .rst (rst),
            .bus (t3_if)
        );
        int n3    = 0;
        int last3 = 0;
        bit fin3  = 1'b0;
        always @(negedge clk) begin
            if (t3_on && t3_if.rk_valid && n3 < 44) begin
                chk("t3_word", t3_if.rk_word, t1_w[n3]);
                if (n3 > 0)
                    chk("t3_gap", 32'(cyc - last3), 32'(gap_exp(n3, L, P)));
                last3 = cyc;
                n3    = n3 + 1;
            end
            if (t3_fin && !fin3) begin
                chk("t3_count", 32'(n3), 32'd44);
                fin3 = 1'b1;
            end
        end
    end

    bit          mon_on = 1'b0;
    int          n_acc  = 44;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_word;
    logic [5:0]  prev_idx;

    always @(negedge clk) begin
        if (mon_on) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.rk_valid), 32'd1);
                chk("hold_word", bus.rk_word, prev_word);
                chk("hold_index", 32'(bus.rk_index), 32'(prev_idx));
            end
            prev_stall = bus.rk_valid && !bus.rk_ready && !bus.abort && !rst;
            prev_word  = bus.rk_word;
            prev_idx   = bus.rk_index;
            if (bus.rk_valid && bus.rk_ready && !bus.abort && !rst && n_acc < 44) begin
                chk("word", bus.rk_word, exp_w[n_acc]);
                chk("index", 32'(bus.rk_index), 32'(n_acc));
                chk("round", 32'(bus.rk_round), 32'(n_acc / 4));
                chk("last", 32'(bus.rk_last), 32'(n_acc == 43));
                got_w[n_acc] = bus.rk_word;
                n_acc++;
            end
        end
    end

    task automatic load_key(input logic [127:0] k);
        int t;
        t = 0;
        while (!bus.key_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("key_ready_idle", 32'(bus.key_ready), 32'd1);
        model(k);
        n_acc = 0;
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        chk("busy_after_load", 32'(bus.busy), 32'd1);
    endtask

    task automatic run(
        input int pct,
        input int ab_at,
        input int rs_at,
        input int kv_at,
        input bit kr_chk
    );
        int c;
        bit done;
        c    = 0;
        done = 1'b0;
        while (!done && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
            bus.abort     = 1'b0;
            bus.key_valid = 1'b0;
            rst           = 1'b0;
            if (kr_chk)
                chk("key_ready_busy", 32'(bus.key_ready), 32'(n_acc == 44));
            if (n_acc == 44) begin
                done = 1'b1;
            end else if (ab_at >= 0 && bus.rk_valid && bus.rk_index == 6'(ab_at)) begin
                bus.abort    = 1'b1;
                bus.rk_ready = 1'b1;
                done         = 1'b1;
            end else if (rs_at >= 0 && n_acc == rs_at && !bus.rk_valid) begin
                rst  = 1'b1;
                done = 1'b1;
            end else begin
                if (kv_at >= 0 && n_acc == kv_at && bus.rk_valid) begin
                    bus.key_in    = ALT_KEY;
                    bus.key_valid = 1'b1;
                end
                bus.rk_ready = ($urandom_range(99) < pct);
            end
        end
        if (!done) chk("stream_timeout", 32'(n_acc), 32'd44);
        @(posedge clk);
        #1;
        bus.abort     = 1'b0;
        bus.key_valid = 1'b0;
        bus.rk_ready  = 1'b0;
        rst           = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.key_in    = '0;
        bus.key_valid = 1'b0;
        bus.abort     = 1'b0;
        bus.rk_ready  = 1'b0;
        model(T1_KEY);
        t1_w = exp_w;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.rk_valid), 32'd0);
        chk("rst_last", 32'(bus.rk_last), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_key_ready", 32'(bus.key_ready), 32'd1);
        chk("rst_word", bus.rk_word, 32'h0);
        chk("rst_index", 32'(bus.rk_index), 32'd0);
        chk("rst_round", 32'(bus.rk_round), 32'd0);
        rst = 1'b0;

        t3_on = 1'b1;
        t3_kv = 1'b1;
        @(posedge clk);
        #1;
        t3_kv = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        t3_fin = 1'b1;
        @(posedge clk);
        #1;
        t3_on  = 1'b0;
        mon_on = 1'b1;

        load_key(T1_KEY);
        run(100, -1, -1, -1, 1'b0);
        chk("a1_w0", got_w[0], 32'h2b7e1516);
        chk("a1_w3", got_w[3], 32'h09cf4f3c);
        chk("a1_w4", got_w[4], 32'ha0fafe17);
        chk("a1_w5", got_w[5], 32'h88542cb1);
        chk("a1_w6", got_w[6], 32'h23a33939);
        chk("a1_w7", got_w[7], 32'h2a6c7605);
        chk("a1_w43", got_w[43], 32'hb6630ca6);
        chk("idle_after", 32'(bus.key_ready), 32'd1);

        load_key(T1_KEY);
        run(50, -1, -1, -1, 1'b0);
        chk("stall_w43", got_w[43], 32'hb6630ca6);

        repeat (3) begin
            load_key({$urandom, $urandom, $urandom, $urandom});
            run(int'($urandom_range(90, 30)), -1, -1, -1, 1'b0);
        end

        load_key(T1_KEY);
        run(60, 17, -1, -1, 1'b0);
        chk("abort_count", 32'(n_acc), 32'd17);
        chk("abort_valid", 32'(bus.rk_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_key_ready", 32'(bus.key_ready), 32'd1);
        load_key(C1_KEY);
        run(100, -1, -1, -1, 1'b0);
        chk("c1_w40", got_w[40], 32'h13111d7f);
        chk("c1_w43", got_w[43], 32'h4d2b30c5);

        load_key(T1_KEY);
        run(100, -1, 24, -1, 1'b0);
        chk("rst_mid_count", 32'(n_acc), 32'd24);
        chk("rst_mid_valid", 32'(bus.rk_valid), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_key_ready", 32'(bus.key_ready), 32'd1);
        chk("rst_mid_index", 32'(bus.rk_index), 32'd0);
        load_key(T1_KEY);
        run(100, -1, -1, -1, 1'b0);
        chk("after_rst_w43", got_w[43], 32'hb6630ca6);

        load_key(T1_KEY);
        run(100, -1, -1, 10, 1'b1);
        chk("ignore_key_w43", got_w[43], 32'hb6630ca6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
